// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-group intersection controller
// with pedestrian windows, hold, night flash and status.
module traffic_ctrl_param #(
  parameter int N_DIR         = 4,
  parameter int T_GREEN       = 20,
  parameter int T_YELLOW      = 2,
  parameter int T_LEFT        = 10,
  parameter int T_WALK        = 14,
  parameter int T_BLINK       = 6,
  parameter int PED_ON_DEMAND = 1,
  parameter int CW            = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic                 i_night,
  input  logic [N_DIR-1:0]     i_ped_req,
  output logic [4*N_DIR-1:0]   o_car,
  output logic [2*N_DIR-1:0]   o_walk,
  output logic [3:0]           o_phase,
  output logic [CW-1:0]        o_remain
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    A_GRN = 4'd1,
    A_Y1  = 4'd2,
    A_LFT = 4'd3,
    A_Y2  = 4'd4,
    B_GRN = 4'd5,
    B_Y1  = 4'd6,
    B_LFT = 4'd7,
    B_Y2  = 4'd8,
    NIGHT = 4'd9
  } state_t;

  localparam logic [CW-1:0] TW  = CW'(T_WALK);
  localparam logic [CW-1:0] TWB = CW'(T_WALK + T_BLINK);
  localparam logic ALWAYS = (PED_ON_DEMAND == 0);

  localparam logic [3:0] C_RED = 4'b1000;
  localparam logic [3:0] C_YEL = 4'b0100;
  localparam logic [3:0] C_LFT = 4'b0010;
  localparam logic [3:0] C_GRN = 4'b0001;
  localparam logic [1:0] W_RED = 2'b10;
  localparam logic [1:0] W_GRN = 2'b01;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [CW-1:0] h, nxt_h;
  logic          pend_a, nxt_pend_a;
  logic          pend_b, nxt_pend_b;
  logic          grant_a, nxt_grant_a;
  logic          grant_b, nxt_grant_b;
  logic          flash, nxt_flash;
  logic          req_a, req_b, running;
  logic          a_active, grant_idle;
  logic [3:0]    lamp;
  logic [1:0]    walk_idle;
  logic [4*N_DIR-1:0] nxt_car;
  logic [2*N_DIR-1:0] nxt_walk;

  function automatic logic [CW-1:0] load(input state_t s);
    case (s)
      A_GRN, B_GRN: load = CW'(T_GREEN - 1);
      A_Y1, A_Y2,
      B_Y1, B_Y2:   load = CW'(T_YELLOW - 1);
      A_LFT, B_LFT: load = CW'(T_LEFT - 1);
      default:      load = '0;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      A_GRN:   succ = A_Y1;
      A_Y1:    succ = A_LFT;
      A_LFT:   succ = A_Y2;
      A_Y2:    succ = B_GRN;
      B_GRN:   succ = B_Y1;
      B_Y1:    succ = B_LFT;
      B_LFT:   succ = B_Y2;
      B_Y2:    succ = A_GRN;
      default: succ = s;
    endcase
  endfunction

  assign running = (state != IDLE) && (state != NIGHT);

  // Collapse per-approach buttons into one request per group.
  always_comb begin
    req_a = 1'b0;
    req_b = 1'b0;
    for (int k = 0; k < N_DIR; k++) begin
      if ((k % 2) == 0) req_a = req_a | i_ped_req[k];
      else              req_b = req_b | i_ped_req[k];
    end
  end

  // Next state, phase counter, half elapsed and request bookkeeping.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_h       = h;
    nxt_pend_a  = pend_a;
    nxt_pend_b  = pend_b;
    nxt_grant_a = grant_a;
    nxt_grant_b = grant_b;
    nxt_flash   = 1'b0;
    if (i_night) begin
      nxt_state   = NIGHT;
      nxt_cnt     = '0;
      nxt_h       = '0;
      nxt_pend_a  = 1'b0;
      nxt_pend_b  = 1'b0;
      nxt_grant_a = 1'b0;
      nxt_grant_b = 1'b0;
      nxt_flash   = (state == NIGHT) ? ~flash : 1'b1;
    end else if (!running) begin
      if (i_start) begin
        nxt_state   = A_GRN;
        nxt_cnt     = load(A_GRN);
        nxt_h       = '0;
        nxt_grant_b = ALWAYS | pend_b | req_b;
        nxt_pend_b  = 1'b0;
      end else begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_h     = '0;
      end
    end else begin
      nxt_pend_a = pend_a | req_a;
      nxt_pend_b = pend_b | req_b;
      if (i_start) begin
        if (cnt == '0) begin
          nxt_state = succ(state);
          nxt_cnt   = load(nxt_state);
          nxt_h     = h + CW'(1);
          if (nxt_state == A_GRN) begin
            nxt_h       = '0;
            nxt_grant_b = ALWAYS | pend_b | req_b;
            nxt_pend_b  = 1'b0;
          end
          if (nxt_state == B_GRN) begin
            nxt_h       = '0;
            nxt_grant_a = ALWAYS | pend_a | req_a;
            nxt_pend_a  = 1'b0;
          end
        end else begin
          nxt_cnt = cnt - CW'(1);
          nxt_h   = h + CW'(1);
        end
      end
    end
  end

  // Lamp pattern for the upcoming state, registered below.
  always_comb begin
    nxt_car  = '0;
    nxt_walk = '0;
    a_active = (nxt_state == A_GRN) || (nxt_state == A_Y1) ||
               (nxt_state == A_LFT) || (nxt_state == A_Y2);
    grant_idle = a_active ? nxt_grant_b : nxt_grant_a;
    case (nxt_state)
      A_GRN, B_GRN: lamp = C_GRN;
      A_LFT, B_LFT: lamp = C_LFT;
      A_Y1, A_Y2,
      B_Y1, B_Y2:   lamp = C_YEL;
      NIGHT:        lamp = nxt_flash ? C_YEL : 4'b0000;
      default:      lamp = 4'b0000;
    endcase
    if (grant_idle && (nxt_h < TW))
      walk_idle = W_GRN;
    else if (grant_idle && (nxt_h < TWB))
      walk_idle = (nxt_h[0] ^ TW[0]) ? 2'b00 : W_GRN;
    else
      walk_idle = W_RED;
    for (int k = 0; k < N_DIR; k++) begin
      if ((nxt_state == IDLE) || (nxt_state == NIGHT)) begin
        nxt_car[4*k +: 4]  = lamp;
        nxt_walk[2*k +: 2] = 2'b00;
      end else if (((k % 2) == 0) == a_active) begin
        nxt_car[4*k +: 4]  = lamp;
        nxt_walk[2*k +: 2] = W_RED;
      end else begin
        nxt_car[4*k +: 4]  = C_RED;
        nxt_walk[2*k +: 2] = walk_idle;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      h       <= '0;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      flash   <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      h       <= nxt_h;
      pend_a  <= nxt_pend_a;
      pend_b  <= nxt_pend_b;
      grant_a <= nxt_grant_a;
      grant_b <= nxt_grant_b;
      flash   <= nxt_flash;
    end
  end

  // Output register, updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_car    <= '0;
      o_walk   <= '0;
      o_phase  <= 4'd0;
      o_remain <= '0;
    end else begin
      o_car    <= nxt_car;
      o_walk   <= nxt_walk;
      o_phase  <= nxt_state;
      o_remain <= nxt_cnt;
    end
  end

endmodule
